aw_fifo_drain: RTL and testbench
================================

Name: aw_fifo_drain

Overview:
- AXI-side consumer of the packed 45-bit write-address word produced by the master-to-AXI AW clock-domain-crossing FIFO.
- Pops one entry at a time from the FIFO read port, unpacks it into registered AXI AW channel signals, and holds AWVALID until AWREADY.
- Counts outstanding write bursts, retiring one per B-channel handshake, and stops issuing when MAX_OUTST bursts are in flight.
- Sits in the AXI clock domain between the FIFO read side and the interconnect master port.

Parameters:
- MAX_OUTST, 4: maximum in-flight AW bursts awaiting a B response; legal range 1..15.
- CNT_W, $clog2(MAX_OUTST+1): outstanding counter width; derived, never overridden.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- fifo_rdata  in  45  packed AW word: [1:0] BURST, [4:2] SIZE, [8:5] LEN, [40:9] ADDR, [44:41] ID; valid only when fifo_rempty=0
- fifo_rempty  in  1  FIFO empty
- fifo_rpop  out  1  pop strobe, one cycle per entry consumed
- AWID_M  out  4  AXI AWID
- AWADDR_M  out  32  AXI AWADDR
- AWLEN_M  out  4  AXI AWLEN
- AWSIZE_M  out  3  AXI AWSIZE
- AWBURST_M  out  2  AXI AWBURST
- AWVALID_M  out  1  AXI AWVALID
- AWREADY_M  in  1  AXI AWREADY
- BVALID_M  in  1  AXI BVALID
- BREADY_M  out  1  AXI BREADY
- outst_cnt  out  CNT_W  current outstanding burst count

Behaviour:
- Reset (ARESETn=0, async): state=IDLE, AWVALID_M=0, AW* payload=0, outst_cnt=0, fifo_rpop=0, BREADY_M=0. An AW in flight is dropped; the upstream FIFO is reset with this block.
- fifo_rpop is combinational. It asserts only when fifo_rempty=0 and the load condition below holds, so it never pops an empty FIFO.
- Load condition: `fifo_rempty=0 && (outst_cnt + pending) < MAX_OUTST`.
  - pending = 1 if an AW handshake occurs in the same cycle, else 0.
- State IDLE (AWVALID_M=0):
  - If the load condition holds: fifo_rpop=1 and the fifo_rdata fields are registered.
  - Next state SEND, with AWVALID_M=1 on the following cycle. Latency from non-empty FIFO to AWVALID_M is 1 cycle.
- State SEND (AWVALID_M=1):
  - Payload and AWVALID_M are held stable until AWREADY_M=1. AWVALID_M is never deasserted without a handshake.
  - On handshake, if the load condition holds (pending=1): pop and reload in the same cycle and stay in SEND. Back-to-back AWs give 1 address per cycle.
  - On handshake otherwise: go to IDLE with AWVALID_M=0.
- Counter: +1 on `AWVALID_M && AWREADY_M`; -1 on `BVALID_M && BREADY_M`. Both in the same cycle: no change.
- BREADY_M = (outst_cnt != 0), registered-free combinational. A B response with outst_cnt=0 is not accepted.
- Saturation: outst_cnt never exceeds MAX_OUTST and never wraps below 0. When outst_cnt=MAX_OUTST, no load occurs until a B handshake.
- With MAX_OUTST=1, each AW waits for its B handshake before the next pop.
- The payload is transported unmodified; no field is checked or altered.

Optional Feature:
- Macro AW_DRAIN_ERR_EN.
- Defined:
  - Adds output `b_unexp_err` (1 bit, reset 0). It is sticky-set when BVALID_M=1 for 2 consecutive cycles while outst_cnt=0, and clears only on reset.
  - Adds output `aw_stall_cyc` (16 bits, reset 0). It counts cycles in SEND without AWREADY_M, saturates at 0xFFFF, and resets to 0 on each handshake.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset then single entry:
  - Stimulus: fifo_rdata={ID=4'h3, ADDR=32'h1000_0040, LEN=4'd3, SIZE=3'd2, BURST=2'b01}, fifo_rempty 1->0.
  - Response: fifo_rpop=1 for 1 cycle. Next cycle AWVALID_M=1, AWID_M=3, AWADDR_M=0x10000040, AWLEN_M=3, AWSIZE_M=2, AWBURST_M=1. Cleared the cycle after AWREADY_M=1; outst_cnt=1.
- Backpressure:
  - Stimulus: hold AWREADY_M=0 for 5 cycles with a new FIFO entry waiting.
  - Response: payload unchanged, fifo_rpop=0 throughout, and exactly 1 pop in the handshake cycle.
- Outstanding limit, MAX_OUTST=4:
  - Stimulus: 6 FIFO entries, AWREADY_M=1, no B.
  - Response: 4 handshakes, outst_cnt=4, fifo_rpop stays 0. One BVALID_M pulse then lets exactly 1 more AW issue.
- Simultaneous events:
  - Stimulus: AW handshake and B handshake in the same cycle at outst_cnt=2.
  - Response: outst_cnt stays 2.
- Async reset mid-SEND:
  - Stimulus: ARESETn=0 while AWVALID_M=1.
  - Response: AWVALID_M=0 and outst_cnt=0 immediately, without waiting for a clock edge.
- AW_DRAIN_ERR_EN build:
  - Stimulus: BVALID_M=1 for 2 cycles with outst_cnt=0.
  - Response: b_unexp_err=1 and stays 1 until reset; BREADY_M stays 0.

Source files
------------

// File: rtl/aw_fifo_drain_if.sv
// Bundle between the AW CDC FIFO read port, the AXI AW/B channels and the drain block.
// master: the drain block (pops the FIFO, drives AW, accepts B); slave: the FIFO/interconnect side.
interface aw_fifo_drain_if;
  // FIFO read port: fifo_rdata is meaningful only while fifo_rempty is low.
  logic [44:0] fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rpop;

  // AXI handshake rule for AW and B: a transfer happens on an ACLK rising edge where
  // VALID and READY are both high; VALID, once raised, stays high with a stable payload
  // until that edge, and READY may change at any time.
  logic [3:0]  AWID_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M;
  logic        AWREADY_M;
  logic        BVALID_M;
  logic        BREADY_M;

  modport master (
    input  fifo_rdata, fifo_rempty, AWREADY_M, BVALID_M,
    output fifo_rpop, AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M, BREADY_M
  );

  modport slave (
    output fifo_rdata, fifo_rempty, AWREADY_M, BVALID_M,
    input  fifo_rpop, AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M, BREADY_M
  );
endinterface

// File: rtl/aw_fifo_drain.sv
// Drains packed AW words from the AW CDC FIFO onto the AXI AW channel, bounding in-flight bursts.
// Optional macro AW_DRAIN_ERR_EN adds b_unexp_err (unexpected B) and aw_stall_cyc (AW stall counter).
module aw_fifo_drain #(
  parameter  int MAX_OUTST = 4,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  aw_fifo_drain_if.master  bus,
  output logic [CNT_W-1:0] outst_cnt,
  output logic             state_dbg
`ifdef AW_DRAIN_ERR_EN
  ,
  output logic             b_unexp_err,
  output logic [15:0]      aw_stall_cyc
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W:0]   MAX_SUM = (CNT_W + 1)'(MAX_OUTST);

  state_t           state, state_nxt;
  logic             aw_hs, b_hs, load_ok;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  assign bus.AWVALID_M = (state == SEND);
  assign state_dbg     = (state == SEND);

  // A handshake this cycle frees the output register but adds one more in-flight burst,
  // so it is counted before deciding whether the next word may be loaded.
  always_comb begin
    aw_hs        = bus.AWVALID_M && bus.AWREADY_M;
    bus.BREADY_M = (outst_cnt != '0);
    b_hs         = bus.BVALID_M && bus.BREADY_M;
    cnt_sum      = {1'b0, outst_cnt} + (CNT_W + 1)'(aw_hs);
    load_ok      = !bus.fifo_rempty && (cnt_sum < MAX_SUM);
    bus.fifo_rpop = load_ok && ((state == IDLE) || aw_hs);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.fifo_rpop) state_nxt = SEND;
      SEND: if (aw_hs && !bus.fifo_rpop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus.AWID_M    <= '0;
      bus.AWADDR_M  <= '0;
      bus.AWLEN_M   <= '0;
      bus.AWSIZE_M  <= '0;
      bus.AWBURST_M <= '0;
    end else if (bus.fifo_rpop) begin
      bus.AWBURST_M <= bus.fifo_rdata[1:0];
      bus.AWSIZE_M  <= bus.fifo_rdata[4:2];
      bus.AWLEN_M   <= bus.fifo_rdata[8:5];
      bus.AWADDR_M  <= bus.fifo_rdata[40:9];
      bus.AWID_M    <= bus.fifo_rdata[44:41];
    end
  end

  // Simultaneous AW and B handshakes cancel; the bounds guard against wrap either way.
  always_comb begin
    cnt_nxt = outst_cnt;
    if (aw_hs && !b_hs && (outst_cnt != MAX_CNT))
      cnt_nxt = outst_cnt + CNT_W'(1);
    else if (b_hs && !aw_hs && (outst_cnt != '0))
      cnt_nxt = outst_cnt - CNT_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) outst_cnt <= '0;
    else          outst_cnt <= cnt_nxt;
  end

`ifdef AW_DRAIN_ERR_EN
  logic b_unexp_q;
  logic b_unexp_now;

  assign b_unexp_now = bus.BVALID_M && (outst_cnt == '0);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      b_unexp_q   <= 1'b0;
      b_unexp_err <= 1'b0;
    end else begin
      b_unexp_q <= b_unexp_now;
      if (b_unexp_q && b_unexp_now) b_unexp_err <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      aw_stall_cyc <= '0;
    else if (aw_hs)
      aw_stall_cyc <= '0;
    else if ((state == SEND) && !bus.AWREADY_M && (aw_stall_cyc != 16'hFFFF))
      aw_stall_cyc <= aw_stall_cyc + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aw_fifo_drain.sv
// Randomized and directed bench for aw_fifo_drain against a transaction-level reference model.
// Build with +define+AW_DRAIN_ERR_EN to also exercise b_unexp_err and aw_stall_cyc.
module tb_aw_fifo_drain;
  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = $clog2(MAX_OUTST + 1);

  // clock / reset
  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  aw_fifo_drain_if bus ();
  logic [CNT_W-1:0] outst_cnt;
  logic             state_dbg;
`ifdef AW_DRAIN_ERR_EN
  logic             b_unexp_err;
  logic [15:0]      aw_stall_cyc;
`endif

  aw_fifo_drain #(.MAX_OUTST(MAX_OUTST)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .bus       (bus),
    .outst_cnt (outst_cnt),
    .state_dbg (state_dbg)
`ifdef AW_DRAIN_ERR_EN
    ,
    .b_unexp_err  (b_unexp_err),
    .aw_stall_cyc (aw_stall_cyc)
`endif
  );

  int checks = 0;
  int errors = 0;

  // environment FIFO contents, model copy of not-yet-popped words, scoreboard of issue order
  logic [44:0] env_q[$];
  logic [44:0] m_q[$];
  logic [44:0] exp_q[$];

  // reference model: in-flight count, word presented on AW (if any), error/stall tracking
  int          m_cnt;
  bit          m_valid;
  logic [44:0] m_cur;
  bit          m_err;
  bit          m_prev_unexp;
  int          m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [44:0] pack(input logic [3:0] id, input logic [31:0] addr,
                                       input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
    return {id, addr, len, size, burst};
  endfunction

  function automatic logic [63:0] aw_word();
    return {19'b0, bus.AWID_M, bus.AWADDR_M, bus.AWLEN_M, bus.AWSIZE_M, bus.AWBURST_M};
  endfunction

  function automatic logic [44:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[44:0];
  endfunction

  task automatic model_reset();
    env_q.delete();
    m_q.delete();
    exp_q.delete();
    m_cnt        = 0;
    m_valid      = 1'b0;
    m_cur        = '0;
    m_err        = 1'b0;
    m_prev_unexp = 1'b0;
    m_stall      = 0;
  endtask

  // driver: one ACLK cycle. Inputs driven at negedge, outputs checked 1ns later, state
  // advanced at posedge. push enqueues pd into the FIFO, visible from the next cycle.
  task automatic step(input bit push, input logic [44:0] pd, input bit awr, input bit bv);
    bit hs, pop, bhs, dut_pop, dut_hs, unexp;
    @(negedge ACLK);
    bus.AWREADY_M   = awr;
    bus.BVALID_M    = bv;
    bus.fifo_rempty = (env_q.size() == 0);
    bus.fifo_rdata  = (env_q.size() != 0) ? env_q[0] : '0;
    #1;
    hs    = m_valid && awr;
    bhs   = bv && (m_cnt != 0);
    pop   = (m_q.size() != 0) && ((m_cnt + int'(hs)) < MAX_OUTST) && (!m_valid || hs);
    unexp = bv && (m_cnt == 0);

    check_eq("rpop",      64'(bus.fifo_rpop), 64'(pop));
    check_eq("awvalid",   64'(bus.AWVALID_M), 64'(m_valid));
    check_eq("state_dbg", 64'(state_dbg),     64'(m_valid));
    check_eq("bready",    64'(bus.BREADY_M),  64'(m_cnt != 0));
    check_eq("outst_cnt", 64'(outst_cnt),     64'(m_cnt));
    if (m_valid) check_eq("payload", aw_word(), 64'(m_cur));
`ifdef AW_DRAIN_ERR_EN
    check_eq("b_unexp_err",  64'(b_unexp_err),  64'(m_err));
    check_eq("aw_stall_cyc", 64'(aw_stall_cyc), 64'(m_stall));
`endif

    // scoreboard: every AW handshake must carry the oldest word not yet issued
    dut_pop = bus.fifo_rpop;
    dut_hs  = bus.AWVALID_M && awr;
    if (dut_hs) begin
      check_eq("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("sb_aw_order", aw_word(), 64'(exp_q.pop_front()));
    end

    @(posedge ACLK);
    if (dut_pop && env_q.size() != 0) void'(env_q.pop_front());
    if (push) env_q.push_back(pd);

    if (hs) m_stall = 0;
    else if (m_valid && !awr && m_stall < 65535) m_stall++;
    if (m_prev_unexp && unexp) m_err = 1'b1;
    m_prev_unexp = unexp;
    m_cnt = m_cnt + int'(hs) - int'(bhs);
    if (pop) begin
      m_cur   = m_q.pop_front();
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (push) begin
      m_q.push_back(pd);
      exp_q.push_back(pd);
    end
  endtask

  task automatic drain_all();
    for (int i = 0; i < 100 && (m_cnt != 0 || m_valid || m_q.size() != 0); i++)
      step(1'b0, '0, 1'b1, 1'b1);
    check_eq("drain_done", 64'(m_cnt != 0 || m_valid || m_q.size() != 0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn         = 1'b0;
    bus.fifo_rdata  = '0;
    bus.fifo_rempty = 1'b1;
    bus.AWREADY_M   = 1'b0;
    bus.BVALID_M    = 1'b0;
    model_reset();
    repeat (3) @(negedge ACLK);
    #1;
    check_eq("rst_awvalid", 64'(bus.AWVALID_M), 64'd0);
    check_eq("rst_payload", aw_word(),          64'd0);
    check_eq("rst_cnt",     64'(outst_cnt),     64'd0);
    check_eq("rst_rpop",    64'(bus.fifo_rpop), 64'd0);
    check_eq("rst_bready",  64'(bus.BREADY_M),  64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // single entry: pop next cycle, AWVALID one cycle later, handshake retires into count
    step(1'b1, pack(4'h3, 32'h1000_0040, 4'd3, 3'd2, 2'b01), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    #1;
    check_eq("single_cnt", 64'(outst_cnt), 64'd1);
    check_eq("single_awvalid_clr", 64'(bus.AWVALID_M), 64'd0);

    // backpressure: held payload, no pop while a second word waits, pop on handshake
    step(1'b1, rand_word(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    drain_all();

    // outstanding limit: six words, no B, only MAX_OUTST issue until one B arrives
    repeat (6) step(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    check_eq("limit_cnt",  64'(outst_cnt),    64'(MAX_OUTST));
    check_eq("limit_left", 64'(env_q.size()), 64'd2);
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    check_eq("limit_after_b_cnt",  64'(outst_cnt),    64'(MAX_OUTST));
    check_eq("limit_after_b_left", 64'(env_q.size()), 64'd1);

    // simultaneous AW and B handshakes at count 2
    for (int i = 0; i < 20 && !(m_cnt == 2 && m_valid); i++)
      step(1'b0, '0, 1'b0, m_cnt > 2);
    check_eq("sim_setup", 64'(m_cnt == 2 && m_valid), 64'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    #1;
    check_eq("sim_cnt", 64'(outst_cnt), 64'd2);

    // asynchronous reset while AWVALID is high
    step(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 10 && !m_valid; i++) step(1'b0, '0, 1'b0, 1'b0);
    @(negedge ACLK);
    #2;
    ARESETn = 1'b0;
    #1;
    check_eq("arst_awvalid", 64'(bus.AWVALID_M), 64'd0);
    check_eq("arst_cnt",     64'(outst_cnt),     64'd0);
    check_eq("arst_bready",  64'(bus.BREADY_M),  64'd0);
    model_reset();
    bus.AWREADY_M   = 1'b0;
    bus.BVALID_M    = 1'b0;
    bus.fifo_rempty = 1'b1;
    @(negedge ACLK);
    ARESETn = 1'b1;

    // B with nothing outstanding: never accepted; two in a row flag an error when enabled
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // randomized traffic
    repeat (600)
      step($urandom_range(0, 9) < 4, rand_word(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0);
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
